// File: rtl/matmul_run_sequencer.sv
// matmul_run_sequencer: drives one matmul run over A/B load banks and a C store bank.
// Host writes A/B and reads C. The sequencer hands a start token to the DUT,
// serves its two load ports and captures its sequential stores, then waits
// for the completion token.
// Optional build macro MATMUL_SEQ_CYCLE_COUNT_EN adds the 32-bit cycle_count output.
module matmul_run_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              host_wr_en,
  input  logic              host_wr_sel,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  input  logic [ADDR_W-1:0] host_rd_addr,
  output logic [DATA_W-1:0] host_rd_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   store_count,
  output logic              store_err,
  output logic              in3_valid,
  input  logic              in3_ready,
  input  logic              out0_valid,
  output logic              out0_ready,
  input  logic [ADDR_W-1:0] in0_ld0_addr,
  input  logic              in0_ld0_addr_valid,
  output logic              in0_ld0_addr_ready,
  output logic [DATA_W-1:0] in0_ld0_data,
  output logic              in0_ld0_data_valid,
  input  logic              in0_ld0_data_ready,
  input  logic [ADDR_W-1:0] in1_ld0_addr,
  input  logic              in1_ld0_addr_valid,
  output logic              in1_ld0_addr_ready,
  output logic [DATA_W-1:0] in1_ld0_data,
  output logic              in1_ld0_data_valid,
  input  logic              in1_ld0_data_ready,
  input  logic [DATA_W-1:0] in2_st0,
  input  logic              in2_st0_valid,
  output logic              in2_st0_ready
`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
  ,
  output logic [31:0]       cycle_count
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [DATA_W-1:0] bank_a [DEPTH];
  logic [DATA_W-1:0] bank_b [DEPTH];
  logic [DATA_W-1:0] bank_c [DEPTH];

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             run_entry;
  logic             ld0_addr_hs;
  logic             ld1_addr_hs;
  logic             slot0_next;
  logic             slot1_next;
  logic             st_hs;
  logic [CNT_W-1:0] count_next;
  logic             err_next;
  logic             host_wr_ok;

  // Next-state decode and next values of the run bookkeeping
  always_comb begin
    state_next  = state;
    run_entry   = 1'b0;
    ld0_addr_hs = in0_ld0_addr_valid & in0_ld0_addr_ready;
    ld1_addr_hs = in1_ld0_addr_valid & in1_ld0_addr_ready;
    st_hs       = in2_st0_valid & in2_st0_ready;
    slot0_next  = in0_ld0_data_valid;
    slot1_next  = in1_ld0_data_valid;
    count_next  = store_count;
    err_next    = store_err;
    host_wr_ok  = host_wr_en & ((state == IDLE) | (state == DONE));

    case (state)
      IDLE:    if (start) state_next = START;
      START: begin
        if (in3_valid && in3_ready) begin
          state_next = RUN;
          run_entry  = 1'b1;
        end
      end
      RUN:     if (out0_valid && out0_ready) state_next = DONE;
      DONE:    if (start) state_next = START;
      default: state_next = IDLE;
    endcase

    // A slot is only re-armed after its data has been taken, so fill and drain never overlap
    if (ld0_addr_hs)                                        slot0_next = 1'b1;
    else if (in0_ld0_data_valid && in0_ld0_data_ready)      slot0_next = 1'b0;
    if (ld1_addr_hs)                                        slot1_next = 1'b1;
    else if (in1_ld0_data_valid && in1_ld0_data_ready)      slot1_next = 1'b0;

    if (st_hs) count_next = store_count + CNT_W'(1);
    if ((state == RUN) && in2_st0_valid && (store_count == CNT_FULL)) err_next = 1'b1;

    if (run_entry) begin
      slot0_next = 1'b0;
      slot1_next = 1'b0;
      count_next = '0;
      err_next   = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Registered handshake/status outputs, computed from next-cycle values
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in3_valid          <= 1'b0;
      out0_ready         <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      in0_ld0_addr_ready <= 1'b0;
      in1_ld0_addr_ready <= 1'b0;
      in0_ld0_data_valid <= 1'b0;
      in1_ld0_data_valid <= 1'b0;
      in2_st0_ready      <= 1'b0;
      store_count        <= '0;
      store_err          <= 1'b0;
      host_rd_data       <= '0;
    end else begin
      in3_valid          <= (state_next == START);
      out0_ready         <= (state_next == RUN);
      busy               <= (state_next == START) | (state_next == RUN);
      done               <= (state_next == DONE);
      in0_ld0_addr_ready <= (state_next == RUN) & ~slot0_next;
      in1_ld0_addr_ready <= (state_next == RUN) & ~slot1_next;
      in0_ld0_data_valid <= slot0_next;
      in1_ld0_data_valid <= slot1_next;
      in2_st0_ready      <= (state_next == RUN) & (count_next < CNT_FULL);
      store_count        <= count_next;
      store_err          <= err_next;
      host_rd_data       <= bank_c[host_rd_addr];
    end
  end

  // Bank storage and load data capture (contents are deliberately not reset)
  always_ff @(posedge clock) begin
    if (host_wr_ok && !host_wr_sel) bank_a[host_wr_addr] <= host_wr_data;
    if (host_wr_ok &&  host_wr_sel) bank_b[host_wr_addr] <= host_wr_data;
    if (st_hs) bank_c[store_count[ADDR_W-1:0]] <= in2_st0;
    if (ld0_addr_hs) in0_ld0_data <= bank_a[in0_ld0_addr];
    if (ld1_addr_hs) in1_ld0_data <= bank_b[in1_ld0_addr];
  end

`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
  // RUN-cycle counter: cleared on START entry, saturating, frozen outside RUN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
    end else if ((state_next == START) && (state != START)) begin
      cycle_count <= '0;
    end else if ((state == RUN) && (cycle_count != 32'hFFFF_FFFF)) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_matmul_run_sequencer.sv
// Directed bench for matmul_run_sequencer: table-driven load-port vectors
// plus hand-written store, completion, overflow and reset sequences.
module tb_matmul_run_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        host_wr_en;
  logic        host_wr_sel;
  logic [3:0]  host_wr_addr;
  logic [31:0] host_wr_data;
  logic [3:0]  host_rd_addr;
  logic [31:0] host_rd_data;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  store_count;
  logic        store_err;
  logic        in3_valid;
  logic        in3_ready;
  logic        out0_valid;
  logic        out0_ready;
  logic [3:0]  in0_ld0_addr;
  logic        in0_ld0_addr_valid;
  logic        in0_ld0_addr_ready;
  logic [31:0] in0_ld0_data;
  logic        in0_ld0_data_valid;
  logic        in0_ld0_data_ready;
  logic [3:0]  in1_ld0_addr;
  logic        in1_ld0_addr_valid;
  logic        in1_ld0_addr_ready;
  logic [31:0] in1_ld0_data;
  logic        in1_ld0_data_valid;
  logic        in1_ld0_data_ready;
  logic [31:0] in2_st0;
  logic        in2_st0_valid;
  logic        in2_st0_ready;
`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
  logic [31:0] cycle_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  matmul_run_sequencer #(.DATA_W(32), .ADDR_W(4)) dut (
    .clock              (clock),
    .reset              (reset),
    .host_wr_en         (host_wr_en),
    .host_wr_sel        (host_wr_sel),
    .host_wr_addr       (host_wr_addr),
    .host_wr_data       (host_wr_data),
    .host_rd_addr       (host_rd_addr),
    .host_rd_data       (host_rd_data),
    .start              (start),
    .busy               (busy),
    .done               (done),
    .store_count        (store_count),
    .store_err          (store_err),
    .in3_valid          (in3_valid),
    .in3_ready          (in3_ready),
    .out0_valid         (out0_valid),
    .out0_ready         (out0_ready),
    .in0_ld0_addr       (in0_ld0_addr),
    .in0_ld0_addr_valid (in0_ld0_addr_valid),
    .in0_ld0_addr_ready (in0_ld0_addr_ready),
    .in0_ld0_data       (in0_ld0_data),
    .in0_ld0_data_valid (in0_ld0_data_valid),
    .in0_ld0_data_ready (in0_ld0_data_ready),
    .in1_ld0_addr       (in1_ld0_addr),
    .in1_ld0_addr_valid (in1_ld0_addr_valid),
    .in1_ld0_addr_ready (in1_ld0_addr_ready),
    .in1_ld0_data       (in1_ld0_data),
    .in1_ld0_data_valid (in1_ld0_data_valid),
    .in1_ld0_data_ready (in1_ld0_data_ready),
    .in2_st0            (in2_st0),
    .in2_st0_valid      (in2_st0_valid),
    .in2_st0_ready      (in2_st0_ready)
`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
    ,
    .cycle_count        (cycle_count)
`endif
  );

  typedef struct {
    logic        a_valid;
    logic [3:0]  addr;
    logic        d_ready;
    logic        exp_a_ready;
    logic        exp_d_valid;
    logic        chk_data;
    logic [31:0] exp_d0;
    logic [31:0] exp_d1;
  } ld_vec_t;

  ld_vec_t vec [13];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " in3_valid"},   32'(in3_valid), 32'd0);
    chk({tag, " out0_ready"},  32'(out0_ready), 32'd0);
    chk({tag, " addr_ready0"}, 32'(in0_ld0_addr_ready), 32'd0);
    chk({tag, " addr_ready1"}, 32'(in1_ld0_addr_ready), 32'd0);
    chk({tag, " data_valid0"}, 32'(in0_ld0_data_valid), 32'd0);
    chk({tag, " data_valid1"}, 32'(in1_ld0_data_valid), 32'd0);
    chk({tag, " st_ready"},    32'(in2_st0_ready), 32'd0);
    chk({tag, " store_count"}, 32'(store_count), 32'd0);
    chk({tag, " store_err"},   32'(store_err), 32'd0);
    chk({tag, " busy"},        32'(busy), 32'd0);
    chk({tag, " done"},        32'(done), 32'd0);
    chk({tag, " host_rd_data"}, host_rd_data, 32'd0);
`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
    chk({tag, " cycle_count"}, cycle_count, 32'd0);
`endif
  endtask

  task automatic enter_run();
    start = 1'b1;
    step();
    start = 1'b0;
    in3_ready = 1'b1;
    step();
    in3_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    host_wr_en = 1'b0; host_wr_sel = 1'b0; host_wr_addr = '0; host_wr_data = '0;
    host_rd_addr = '0; start = 1'b0; in3_ready = 1'b0; out0_valid = 1'b0;
    in0_ld0_addr = '0; in0_ld0_addr_valid = 1'b0; in0_ld0_data_ready = 1'b0;
    in1_ld0_addr = '0; in1_ld0_addr_valid = 1'b0; in1_ld0_data_ready = 1'b0;
    in2_st0 = '0; in2_st0_valid = 1'b0;

    // a_valid addr d_ready | a_ready d_valid chk_data d0 d1
    vec[0]  = '{1'b1, 4'd3,  1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 32'h22};
    vec[1]  = '{1'b1, 4'd7,  1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 32'h22};
    vec[2]  = '{1'b1, 4'd7,  1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 32'h22};
    vec[3]  = '{1'b1, 4'd7,  1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 32'h22};
    vec[4]  = '{1'b1, 4'd7,  1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 32'h22};
    vec[5]  = '{1'b1, 4'd7,  1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 32'h22};
    vec[6]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0};
    vec[7]  = '{1'b1, 4'd5,  1'b0, 1'b0, 1'b1, 1'b1, 32'hA5, 32'hB5};
    vec[8]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0};
    vec[9]  = '{1'b1, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hA0, 32'hB0};
    vec[10] = '{1'b1, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0};
    vec[11] = '{1'b1, 4'd15, 1'b0, 1'b0, 1'b1, 1'b1, 32'hAF, 32'hBF};
    vec[12] = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0};

    // Reset state
    step(); step();
    chk_all_zero("reset");
    reset = 1'b1;
    step();

    // Fill A and B in IDLE
    for (int i = 0; i < 16; i++) begin
      host_wr_en = 1'b1; host_wr_sel = 1'b0; host_wr_addr = 4'(i); host_wr_data = 32'hA0 + 32'(i);
      step();
      host_wr_sel = 1'b1; host_wr_data = 32'hB0 + 32'(i);
      step();
    end
    host_wr_sel = 1'b0; host_wr_addr = 4'd3; host_wr_data = 32'h11; step();
    host_wr_sel = 1'b1; host_wr_data = 32'h22; step();
    host_wr_en = 1'b0;

    // START waits for in3_ready
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start in3_valid", 32'(in3_valid), 32'd1);
    chk("start busy", 32'(busy), 32'd1);
    chk("start out0_ready", 32'(out0_ready), 32'd0);
    step();
    chk("start hold in3_valid", 32'(in3_valid), 32'd1);
    in3_ready = 1'b1;
    step();
    in3_ready = 1'b0;
    chk("run in3_valid", 32'(in3_valid), 32'd0);
    chk("run out0_ready", 32'(out0_ready), 32'd1);
    chk("run addr_ready0", 32'(in0_ld0_addr_ready), 32'd1);
    chk("run addr_ready1", 32'(in1_ld0_addr_ready), 32'd1);
    chk("run st_ready", 32'(in2_st0_ready), 32'd1);
    chk("run store_count", 32'(store_count), 32'd0);

    // Host writes and start are ignored during RUN
    host_wr_en = 1'b1; host_wr_sel = 1'b0; host_wr_addr = 4'd5; host_wr_data = 32'hDEAD;
    step();
    host_wr_sel = 1'b1;
    step();
    host_wr_en = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("run start ignored busy", 32'(busy), 32'd1);
    chk("run start ignored in3", 32'(in3_valid), 32'd0);

    // Load port vectors, both ports driven identically
    for (int i = 0; i < 13; i++) begin
      in0_ld0_addr_valid = vec[i].a_valid; in0_ld0_addr = vec[i].addr; in0_ld0_data_ready = vec[i].d_ready;
      in1_ld0_addr_valid = vec[i].a_valid; in1_ld0_addr = vec[i].addr; in1_ld0_data_ready = vec[i].d_ready;
      step();
      chk($sformatf("ld[%0d] addr_ready0", i), 32'(in0_ld0_addr_ready), 32'(vec[i].exp_a_ready));
      chk($sformatf("ld[%0d] addr_ready1", i), 32'(in1_ld0_addr_ready), 32'(vec[i].exp_a_ready));
      chk($sformatf("ld[%0d] data_valid0", i), 32'(in0_ld0_data_valid), 32'(vec[i].exp_d_valid));
      chk($sformatf("ld[%0d] data_valid1", i), 32'(in1_ld0_data_valid), 32'(vec[i].exp_d_valid));
      if (vec[i].chk_data) begin
        chk($sformatf("ld[%0d] data0", i), in0_ld0_data, vec[i].exp_d0);
        chk($sformatf("ld[%0d] data1", i), in1_ld0_data, vec[i].exp_d1);
      end
    end
    in0_ld0_addr_valid = 1'b0; in1_ld0_addr_valid = 1'b0;
    in0_ld0_data_ready = 1'b0; in1_ld0_data_ready = 1'b0;

    // Sixteen stores fill C, then one overflow store
    for (int i = 0; i < 16; i++) begin
      in2_st0_valid = 1'b1; in2_st0 = 32'(i);
      step();
      chk($sformatf("st[%0d] store_count", i), 32'(store_count), 32'(i + 1));
      chk($sformatf("st[%0d] st_ready", i), 32'(in2_st0_ready), (i < 15) ? 32'd1 : 32'd0);
    end
    in2_st0 = 32'h99;
    step();
    in2_st0_valid = 1'b0;
    chk("overflow store_err", 32'(store_err), 32'd1);
    chk("overflow store_count", 32'(store_count), 32'd16);
    chk("overflow st_ready", 32'(in2_st0_ready), 32'd0);

    out0_valid = 1'b1;
    step();
    out0_valid = 1'b0;
    chk("done done", 32'(done), 32'd1);
    chk("done busy", 32'(busy), 32'd0);
    chk("done out0_ready", 32'(out0_ready), 32'd0);
    chk("done store_count", 32'(store_count), 32'd16);
    host_rd_addr = 4'd7;
    step();
    chk("read C[7]", host_rd_data, 32'd7);
    host_rd_addr = 4'd15;
    step();
    chk("read C[15]", host_rd_data, 32'd15);

    // Second run: store coincides with completion
    enter_run();
    chk("run2 store_count", 32'(store_count), 32'd0);
    chk("run2 store_err", 32'(store_err), 32'd0);
    chk("run2 done", 32'(done), 32'd0);
    in2_st0_valid = 1'b1; in2_st0 = 32'h55; out0_valid = 1'b1;
    step();
    in2_st0_valid = 1'b0; out0_valid = 1'b0;
    chk("run2 done", 32'(done), 32'd1);
    chk("run2 store_count", 32'(store_count), 32'd1);
    host_rd_addr = 4'd0;
    step();
    chk("run2 read C[0]", host_rd_data, 32'h55);

    // Third run: exactly 40 RUN cycles
    enter_run();
    repeat (39) step();
    out0_valid = 1'b1;
    step();
    out0_valid = 1'b0;
    chk("run3 done", 32'(done), 32'd1);
`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
    chk("run3 cycle_count", cycle_count, 32'd40);
    repeat (3) step();
    chk("run3 cycle_count hold", cycle_count, 32'd40);
`endif

    // Fourth run: reset in the middle of RUN
    enter_run();
    for (int i = 0; i < 5; i++) begin
      in2_st0_valid = 1'b1; in2_st0 = 32'h100 + 32'(i);
      step();
    end
    in2_st0_valid = 1'b0;
    chk("run4 store_count", 32'(store_count), 32'd5);
    reset = 1'b0;
    #1;
    chk_all_zero("midrun reset");
    step();
    reset = 1'b1;
    step();
    chk("after reset busy", 32'(busy), 32'd0);
    chk("after reset in3_valid", 32'(in3_valid), 32'd0);
    enter_run();
    chk("run5 store_count", 32'(store_count), 32'd0);
    chk("run5 out0_ready", 32'(out0_ready), 32'd1);
    chk("run5 st_ready", 32'(in2_st0_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
